segasys1_sndlatch: RTL and testbench
====================================

Name: segasys1_sndlatch

Overview:
Sound-CPU-side end of the main-to-sound command path. It accepts the one-cycle SNDRQ/SNDNO write pulse issued by the main CPU block and queues the command in a small FIFO. It raises an edge-style NMI to the sound Z80 for each queued command and presents the command on a read port. It also generates the sound CPU's periodic maskable interrupt.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth; 0 gives a single latch that behaves like the original hardware.
NMI_HOLD, 16, number of CLK48M cycles SNDNMI is held high per command; range 2..255.
IRQ_PERIOD, 200000, CLK48M cycles per periodic IRQ, about 240 Hz.
IRQ_WIDTH, 256, CLK48M cycles SNDIRQ stays high each period; must be less than IRQ_PERIOD.

Ports:
CLK48M  in  1  system clock; only clock
RESET  in  1  reset, synchronous, active-high
SNDRQ  in  1  one-cycle command write strobe from main side
SNDNO  in  8  command byte; sampled when SNDRQ=1
SCPU_RD  in  1  one-cycle read strobe from sound CPU decode, already qualified; exactly one pulse per access
SCPU_DO  out  8  command byte for the sound CPU
SNDNMI  out  1  NMI request to sound CPU, active-high
SNDIRQ  out  1  periodic IRQ request, active-high
SNDCNT  out  DEPTH_LOG2+1  FIFO occupancy
SNDOVF  out  1  sticky overflow flag

Behaviour:
- Interface: one clock, CLK48M; reset is synchronous and active-high (RESET). All state is cleared on a RESET-high clock edge.
- Reset values:
  - SCPU_DO=00, SNDNMI=0, SNDIRQ=0, SNDCNT=0, SNDOVF=0.
  - Pointers=0, NMI FSM=IDLE, IRQ counter=0.
- Reset mid-operation flushes queued commands and drops SNDNMI on the next edge.
- FIFO: circular buffer, depth D=2^DEPTH_LOG2; read and write pointers wrap modulo D.
- Push (SNDRQ=1 at edge n):
  - If not full: write entry, SNDCNT+1 visible at n+1.
  - If full and no simultaneous pop: overwrite the newest entry (last write wins); SNDCNT unchanged; SNDOVF set to 1 and held until RESET.
- Pop (SCPU_RD=1, SNDCNT>0):
  - Read pointer advances; SNDCNT-1.
  - Read while empty: no pop, SCPU_DO unchanged.
- Simultaneous push and pop:
  - Non-empty: count unchanged; if full, the push uses the freed slot, with no overwrite and no SNDOVF.
  - Empty: the pop is ignored and the push is accepted; SNDCNT becomes 1.
- SCPU_DO is registered and always equals the head entry when non-empty.
  - Write into an empty FIFO at edge n: SCPU_DO valid at n+1.
  - After a pop: the next head is valid on the following cycle.
  - When the FIFO goes empty, SCPU_DO retains the last popped value, like the original latch.
- NMI FSM, advancing on every clock edge:
  - IDLE: if SNDCNT>0, go to ASSERT. SNDNMI rises one cycle after SNDCNT becomes non-zero, i.e. at n+2 for a push at n.
  - ASSERT: SNDNMI=1 for NMI_HOLD cycles, then go to WAITRD. A pop during ASSERT is honoured and recorded; the FSM still completes the hold.
  - WAITRD: SNDNMI=0. Wait for a pop, or use the one recorded during ASSERT, then go to GAP.
  - GAP: SNDNMI=0 for 2 cycles, then IDLE. If commands remain, a fresh rising edge follows, giving exactly one NMI edge per popped command.
- IRQ generator:
  - Counter runs 0..IRQ_PERIOD-1 and wraps to 0.
  - SNDIRQ is registered, =1 while counter<IRQ_WIDTH; first high cycle is the cycle after reset release.
  - Independent of the FIFO and the NMI FSM.
- Width rules: SNDCNT saturates at D and never wraps; the IRQ counter width is ceil(log2(IRQ_PERIOD)).

Optional Feature:
SEGASYS1_SNDLATCH_IRQGEN_EN.
- Defined: the periodic IRQ generator is built as described.
- Undefined: no counter is instantiated and SNDIRQ is constant 0. IRQ_PERIOD and IRQ_WIDTH are ignored. All FIFO and NMI behaviour is identical in both builds.

Test Plan:
- Reset then SNDRQ with SNDNO=3A at cycle 10 -> SNDCNT=1 and SCPU_DO=3A at cycle 11; SNDNMI high cycles 12..27 (NMI_HOLD=16); low afterwards until a read.
- Push 01,02,03; pop once per NMI after each hold -> SCPU_DO shows 01,02,03 in order; three distinct SNDNMI rising edges, each preceded by ≥2 low cycles; SNDCNT ends 0; SCPU_DO holds 03.
- DEPTH_LOG2=2: push 10,11,12,13,14 with no reads -> SNDCNT=4, SNDOVF=1; pops return 10,11,12,14.
- Full FIFO, SNDRQ(55) and SCPU_RD in the same cycle -> SNDCNT stays 4, SNDOVF stays 0, 55 is read last. Empty FIFO with both strobes -> SNDCNT=1, SCPU_DO=55 next cycle.
- RESET asserted mid-ASSERT with 2 queued -> next edge: SNDNMI=0, SNDCNT=0, SNDOVF=0, SCPU_DO=00; no NMI without a new SNDRQ.
- With the macro and IRQ_PERIOD=100, IRQ_WIDTH=10 -> SNDIRQ high cycles 1..10 after reset and every 100 cycles thereafter. Without the macro -> SNDIRQ constant 0 throughout.

Source files
------------

// File: rtl/segasys1_sndlatch.sv
// Sound-side command latch for the Sega System 1 main-to-sound path.
// A small circular FIFO queues command bytes from the main CPU. An NMI
// sequencer gives one NMI edge per consumed command, and a periodic IRQ
// generator drives the sound CPU's maskable interrupt.
//
// Build option: define SEGASYS1_SNDLATCH_IRQGEN_EN to build the periodic IRQ
// generator. When it is undefined, SNDIRQ is tied low and IRQ_PERIOD and
// IRQ_WIDTH have no effect.
//
// Handshake: SNDRQ and SCPU_RD are single-cycle strobes with no back-pressure.
// A push is always taken; when the FIFO is full, the push overwrites the newest
// entry and sets SNDOVF. A pop is taken only when SNDCNT > 0. SCPU_DO always
// shows the head entry on the cycle after any push or pop.
module segasys1_sndlatch #(
    parameter int DEPTH_LOG2 = 2,
    parameter int NMI_HOLD   = 16,
    parameter int IRQ_PERIOD = 200000,
    parameter int IRQ_WIDTH  = 256
) (
    input  logic                  CLK48M,
    input  logic                  RESET,
    input  logic                  SNDRQ,
    input  logic [7:0]            SNDNO,
    input  logic                  SCPU_RD,
    output logic [7:0]            SCPU_DO,
    output logic                  SNDNMI,
    output logic                  SNDIRQ,
    output logic [DEPTH_LOG2:0]   SNDCNT,
    output logic                  SNDOVF,
    output logic [1:0]            dbg_nmi_state_o
);

    localparam int D  = 1 << DEPTH_LOG2;
    localparam int PW = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
    localparam logic [PW-1:0]       LAST_IDX  = PW'(D - 1);
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(D);
    localparam logic [7:0]          HOLD_LAST = 8'(NMI_HOLD - 1);

    // An illegal parameter combination elaborates this visibly named empty scope.
    if (IRQ_WIDTH >= IRQ_PERIOD || NMI_HOLD < 2 || NMI_HOLD > 255) begin : g_bad_cfg
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST_IDX : p - 1'b1;
    endfunction

    // ---------------- FIFO ----------------
    logic [7:0]          mem_q [0:D-1];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          do_q, do_d;

    logic                empty, full, do_pop, wr_new, wr_ovr, wr_en;
    logic [PW-1:0]       wr_idx;

    // Push/pop decode, pointer and count update, next head value
    always_comb begin
        empty  = (cnt_q == '0);
        full   = (cnt_q == FULL_CNT);
        do_pop = SCPU_RD && !empty;
        // A full FIFO with a simultaneous pop frees a slot, so the push is a normal write
        wr_new = SNDRQ && (!full || do_pop);
        wr_ovr = SNDRQ && full && !do_pop;
        wr_en  = wr_new || wr_ovr;
        wr_idx = wr_ovr ? ptr_dec(wr_ptr_q) : wr_ptr_q;

        wr_ptr_d = wr_new ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        cnt_d = cnt_q;
        case ({wr_new, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        ovf_d = ovf_q | wr_ovr;

        // The head may be written this very cycle, so bypass the incoming byte.
        // When the FIFO is empty, the last popped value is held.
        do_d = do_q;
        if (cnt_d != '0) begin
            do_d = (wr_en && (wr_idx == rd_ptr_d)) ? SNDNO : mem_q[rd_ptr_d];
        end
    end

    // FIFO storage
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            for (int i = 0; i < D; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= SNDNO;
        end
    end

    // FIFO control registers and registered read port
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            do_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            do_q     <= do_d;
        end
    end

    assign SCPU_DO = do_q;
    assign SNDCNT  = cnt_q;
    assign SNDOVF  = ovf_q;

    // ---------------- NMI sequencer ----------------
    typedef enum logic [1:0] {
        NMI_IDLE   = 2'd0,
        NMI_ASSERT = 2'd1,
        NMI_WAITRD = 2'd2,
        NMI_GAP    = 2'd3
    } nmi_state_t;

    nmi_state_t state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic       seen_q, seen_d;
    logic       nmi_q, nmi_d;

    // Next-state logic: hold NMI, wait for the command to be read, then enforce a low gap
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        seen_d  = seen_q;
        case (state_q)
            NMI_IDLE: begin
                if (cnt_q != '0) begin
                    state_d = NMI_ASSERT;
                    tmr_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            NMI_ASSERT: begin
                // An early read is remembered so WAITRD does not wait for a second one
                if (do_pop) seen_d = 1'b1;
                if (tmr_q == HOLD_LAST) begin
                    state_d = NMI_WAITRD;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            NMI_WAITRD: begin
                if (seen_q || do_pop) begin
                    state_d = NMI_GAP;
                    tmr_d   = '0;
                    seen_d  = 1'b0;
                end
            end
            NMI_GAP: begin
                if (tmr_q == 8'd1) begin
                    state_d = NMI_IDLE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: state_d = NMI_IDLE;
        endcase
        nmi_d = (state_d == NMI_ASSERT);
    end

    // NMI sequencer state register
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            state_q <= NMI_IDLE;
            tmr_q   <= '0;
            seen_q  <= 1'b0;
            nmi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            seen_q  <= seen_d;
            nmi_q   <= nmi_d;
        end
    end

    assign SNDNMI          = nmi_q;
    assign dbg_nmi_state_o = state_q;

    // ---------------- Periodic IRQ ----------------
`ifdef SEGASYS1_SNDLATCH_IRQGEN_EN
    localparam int CTR_W = $clog2(IRQ_PERIOD);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(IRQ_PERIOD - 1);
    localparam logic [CTR_W-1:0] CTR_WID  = CTR_W'(IRQ_WIDTH);

    logic [CTR_W-1:0] irq_ctr_q, irq_ctr_d;
    logic             irq_q, irq_d;

    // Free-running period counter; IRQ is high for the first IRQ_WIDTH counts
    always_comb begin
        irq_ctr_d = (irq_ctr_q == CTR_LAST) ? '0 : irq_ctr_q + 1'b1;
        irq_d     = (irq_ctr_q < CTR_WID);
    end

    // IRQ counter and output register
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            irq_ctr_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irq_ctr_q <= irq_ctr_d;
            irq_q     <= irq_d;
        end
    end

    assign SNDIRQ = irq_q;
`else
    assign SNDIRQ = 1'b0;
`endif

endmodule

// File: tb/tb_segasys1_sndlatch.sv
// Directed testbench for segasys1_sndlatch with DEPTH_LOG2=2, NMI_HOLD=16,
// IRQ_PERIOD=100 and IRQ_WIDTH=10. The IRQ expectations follow
// SEGASYS1_SNDLATCH_IRQGEN_EN in the same way as the design build.
module tb_segasys1_sndlatch;

    localparam int DL2 = 2;

    // ---- clock / reset ----
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           rq  = 1'b0;
    logic           rd  = 1'b0;
    logic [7:0]     no  = 8'h00;
    logic [7:0]     dout;
    logic           nmi, irq, ovf;
    logic [DL2:0]   cnt;
    logic [1:0]     dbg;

    segasys1_sndlatch #(
        .DEPTH_LOG2(DL2), .NMI_HOLD(16), .IRQ_PERIOD(100), .IRQ_WIDTH(10)
    ) dut (
        .CLK48M(clk), .RESET(rst), .SNDRQ(rq), .SNDNO(no), .SCPU_RD(rd),
        .SCPU_DO(dout), .SNDNMI(nmi), .SNDIRQ(irq), .SNDCNT(cnt),
        .SNDOVF(ovf), .dbg_nmi_state_o(dbg)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // ---- NMI edge monitor (mid-cycle sampling) ----
    int   rises      = 0;
    int   short_gaps = 0;
    int   low_run    = 100;
    logic nmi_prev   = 1'b0;
    always @(negedge clk) begin
        if (nmi && !nmi_prev) begin
            rises++;
            if (low_run < 2) short_gaps++;
        end
        if (nmi) low_run = 0;
        else if (low_run < 1000) low_run++;
        nmi_prev = nmi;
    end

    // ---- scoreboard check ----
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- driver tasks ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        rq = 1'b1; no = v;
        step();
        rq = 1'b0;
    endtask

    task automatic pop();
        rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; rq = 1'b0; rd = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_nmi_level(input logic lvl);
        for (int i = 0; i < 200 && nmi !== lvl; i++) step();
    endtask

    // ---- stimulus ----
    initial begin
        int hi;
        int r0;
        int g0;
        logic [7:0] e;
        logic exp_irq;

        // Reset values
        rst = 1'b1;
        step(); step();
        check_eq("rst_do",  dout, 8'h00);
        check_eq("rst_nmi", nmi, 1'b0);
        check_eq("rst_irq", irq, 1'b0);
        check_eq("rst_cnt", cnt, 0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_state", dbg, 2'd0);
        rst = 1'b0;
        repeat (9) step();

        // Single command: latency and NMI width
        push(8'h3A);
        check_eq("t1_cnt", cnt, 1);
        check_eq("t1_do",  dout, 8'h3A);
        check_eq("t1_nmi_n1", nmi, 1'b0);
        step();
        check_eq("t1_nmi_n2", nmi, 1'b1);
        hi = 0;
        while (nmi === 1'b1 && hi < 100) begin hi++; step(); end
        check_eq("t1_nmi_width", hi, 16);
        r0 = rises;
        repeat (10) step();
        check_eq("t1_no_refire", rises - r0, 0);
        pop();
        check_eq("t1_cnt_after", cnt, 0);
        check_eq("t1_do_hold", dout, 8'h3A);
        repeat (20) step();
        check_eq("t1_quiet", rises - r0, 0);

        // Three commands, one pop per NMI
        r0 = rises; g0 = short_gaps;
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        push(8'h01); push(8'h02); push(8'h03);
        for (int k = 0; k < 3; k++) begin
            wait_nmi_level(1'b1);
            check_eq("t2_nmi_rise", nmi, 1'b1);
            wait_nmi_level(1'b0);
            check_eq("t2_nmi_fall", nmi, 1'b0);
            e = exp_q.pop_front();
            check_eq("t2_do", dout, e);
            pop();
        end
        check_eq("t2_cnt", cnt, 0);
        check_eq("t2_do_hold", dout, 8'h03);
        repeat (30) step();
        check_eq("t2_rises", rises - r0, 3);
        check_eq("t2_gaps", short_gaps - g0, 0);

        // Overflow: last write wins
        do_reset();
        push(8'h10); push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        check_eq("t3_cnt", cnt, 4);
        check_eq("t3_ovf", ovf, 1'b1);
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        exp_q.push_back(8'h12); exp_q.push_back(8'h14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("t3_do", dout, e);
            pop();
        end
        check_eq("t3_cnt_end", cnt, 0);
        check_eq("t3_ovf_sticky", ovf, 1'b1);
        check_eq("t3_do_hold", dout, 8'h14);

        // Simultaneous push and pop, full then empty
        do_reset();
        check_eq("t4_ovf_clr", ovf, 1'b0);
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        rq = 1'b1; no = 8'h55; rd = 1'b1;
        step();
        rq = 1'b0; rd = 1'b0;
        check_eq("t4_cnt_full", cnt, 4);
        check_eq("t4_ovf", ovf, 1'b0);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3); exp_q.push_back(8'h55);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("t4_do", dout, e);
            pop();
        end
        check_eq("t4_cnt_empty", cnt, 0);
        rq = 1'b1; no = 8'h77; rd = 1'b1;
        step();
        rq = 1'b0; rd = 1'b0;
        check_eq("t4_cnt_one", cnt, 1);
        check_eq("t4_do_77", dout, 8'h77);
        check_eq("t4_ovf_end", ovf, 1'b0);

        // Reset in the middle of an NMI hold
        do_reset();
        push(8'hC1); push(8'hC2);
        wait_nmi_level(1'b1);
        check_eq("t5_nmi_up", nmi, 1'b1);
        step(); step(); step();
        rst = 1'b1;
        step();
        check_eq("t5_nmi", nmi, 1'b0);
        check_eq("t5_cnt", cnt, 0);
        check_eq("t5_ovf", ovf, 1'b0);
        check_eq("t5_do",  dout, 8'h00);
        rst = 1'b0;
        r0 = rises;
        repeat (40) step();
        check_eq("t5_no_nmi", rises - r0, 0);

        // Periodic IRQ, counted from reset release
        rst = 1'b1;
        step(); step();
        check_eq("t6_irq_rst", irq, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= 230; c++) begin
            step();
`ifdef SEGASYS1_SNDLATCH_IRQGEN_EN
            exp_irq = (((c - 1) % 100) < 10);
`else
            exp_irq = 1'b0;
`endif
            check_eq($sformatf("t6_irq_c%0d", c), irq, exp_irq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
